// File: rtl/queue_calc_pkg.sv
// Shared constants for the queue calculator: opcodes, ALU queue actions,
// error codes and the sequencer state encoding.
package queue_calc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned QOP_W  = 2;
  localparam int unsigned ERR_W  = 2;

  localparam logic [OP_W-1:0] OP_PUSH = 4'd0;
  localparam logic [OP_W-1:0] OP_POP  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd4;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd5;
  localparam logic [OP_W-1:0] OP_REM  = 4'd6;
  localparam logic [OP_W-1:0] OP_NOP  = 4'd7;

  localparam logic [QOP_W-1:0] Q_PUSH         = 2'b00;
  localparam logic [QOP_W-1:0] Q_SLEEP        = 2'b01;
  localparam logic [QOP_W-1:0] Q_POP          = 2'b11;
  localparam logic [QOP_W-1:0] Q_GET_AND_PUSH = 2'b10;

  localparam logic [ERR_W-1:0] ERR_NONE      = 2'b00;
  localparam logic [ERR_W-1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [ERR_W-1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [ERR_W-1:0] ERR_CALC      = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  // Two-operand opcodes consume the head pair.
  function automatic logic is_binary(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_REM);
  endfunction

endpackage

// File: rtl/queue_calc_ctrl_circ_queue.sv
// Circular byte FIFO with head/head+1 read ports, one write port and a
// pop-by-0/1/2 control that may coincide with a push.
module circ_queue
  import queue_calc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [1:0]        pop_n,
  output logic [DATA_W-1:0] rd_head,
  output logic [DATA_W-1:0] rd_next,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head_q;
  logic [AW-1:0]     tail_q;

  assign rd_head = mem[head_q];
  assign rd_next = mem[head_q + AW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      head_q <= head_q + AW'(pop_n);
      if (push) tail_q <= tail_q + AW'(1);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop_n);
    end
  end

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= push_data;
  end

endmodule

// File: rtl/queue_calc_ctrl.sv
// Sequencer for the byte-wide queue calculator: instruction handshake,
// operand presentation to the external ALU, queue commit and sticky errors.
module queue_calc_ctrl
  import queue_calc_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [2*DATA_W-1:0] alu_operands,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]   alu_push_val,
  output logic                alu_rst,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [QOP_W-1:0]    alu_queue_op,
  input  logic                alu_calc_err,
  output logic                done,
  output logic                err,
  output logic [ERR_W-1:0]    err_code,
  input  logic                err_clr,
  output logic [AW:0]         count,
  output logic [DATA_W-1:0]   head_data
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ERR_W-1:0]  err_sel;
  logic [DATA_W-1:0] result_q;
  logic [QOP_W-1:0]  qop_q;
  logic              q_push;
  logic [1:0]        q_pop_n;
  logic [DATA_W-1:0] rd_head;
  logic [DATA_W-1:0] rd_next;

  circ_queue #(.DEPTH(DEPTH), .AW(AW)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (result_q),
    .pop_n     (q_pop_n),
    .rd_head   (rd_head),
    .rd_next   (rd_next),
    .count     (count)
  );

  assign alu_operands = {rd_next, rd_head};
  assign head_data    = (count != '0) ? rd_head : '0;

  // Pre-checks take priority over the ALU's own error; only meaningful in EXEC.
  always_comb begin
    err_sel = ERR_NONE;
    if (alu_opcode[3])                                      err_sel = ERR_CALC;
    else if (is_binary(alu_opcode) && count < (AW+1)'(2))   err_sel = ERR_UNDERFLOW;
    else if (alu_opcode == OP_POP && count == '0)           err_sel = ERR_UNDERFLOW;
    else if (alu_opcode == OP_PUSH && count == (AW+1)'(DEPTH)) err_sel = ERR_OVERFLOW;
    else if (alu_calc_err)                                  err_sel = ERR_CALC;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_rst     = rst;
    q_push      = 1'b0;
    q_pop_n     = 2'd0;
    case (state_q)
      S_IDLE: begin
        instr_ready = !rst;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = (err_sel != ERR_NONE) ? S_ERROR : S_COMMIT;
      S_COMMIT: begin
        state_d = S_IDLE;
        case (qop_q)
          Q_PUSH:         q_push = 1'b1;
          Q_POP:          q_pop_n = 2'd1;
          Q_GET_AND_PUSH: begin
            q_pop_n = 2'd2;
            q_push  = 1'b1;
          end
          default: ;
        endcase
      end
      S_ERROR: begin
        if (err_clr) begin
          alu_rst = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // alu_opcode holds the latched op only while in EXEC, NOP otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode   <= OP_NOP;
      alu_push_val <= '0;
      result_q     <= '0;
      qop_q        <= Q_SLEEP;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      done <= (state_q == S_COMMIT);
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            alu_opcode   <= instr_op;
            alu_push_val <= instr_imm;
          end
        end
        S_EXEC: begin
          alu_opcode <= OP_NOP;
          if (err_sel != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= err_sel;
          end else begin
            result_q <= alu_result;
            qop_q    <= alu_queue_op;
          end
        end
        S_ERROR: begin
          if (err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_queue_calc_ctrl.sv
// Bench for queue_calc_ctrl: behavioural ALU, queue reference model,
// directed scenarios followed by a randomized instruction stream.
module tb_queue_calc_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = 4'd0;
  logic [7:0]  instr_imm = 8'd0;
  logic [15:0] alu_operands;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_push_val;
  logic        alu_rst;
  logic [7:0]  alu_result;
  logic [1:0]  alu_queue_op;
  logic        alu_calc_err;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr = 1'b0;
  logic [AW:0] count;
  logic [7:0]  head_data;

  int n_vec = 0;
  int n_miscmp = 0;
  int mq[$];

  always #5 clk = ~clk;

  queue_calc_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_op     (instr_op),
    .instr_imm    (instr_imm),
    .alu_operands (alu_operands),
    .alu_opcode   (alu_opcode),
    .alu_push_val (alu_push_val),
    .alu_rst      (alu_rst),
    .alu_result   (alu_result),
    .alu_queue_op (alu_queue_op),
    .alu_calc_err (alu_calc_err),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .err_clr      (err_clr),
    .count        (count),
    .head_data    (head_data)
  );

  // Behavioural stand-in for the external combinational ALU.
  logic [7:0] op_a, op_b;
  always_comb begin
    op_a         = alu_operands[7:0];
    op_b         = alu_operands[15:8];
    alu_result   = 8'd0;
    alu_queue_op = 2'b01;
    alu_calc_err = 1'b0;
    case (alu_opcode)
      4'd0: begin alu_result = alu_push_val; alu_queue_op = 2'b00; end
      4'd1: alu_queue_op = 2'b11;
      4'd2: begin alu_result = op_a + op_b;     alu_queue_op = 2'b10; end
      4'd3: begin alu_result = 8'(op_a * op_b); alu_queue_op = 2'b10; end
      4'd4: begin alu_result = op_a - op_b;     alu_queue_op = 2'b10; end
      4'd5: begin
        alu_queue_op = 2'b10;
        if (op_b == 8'd0) alu_calc_err = 1'b1;
        else              alu_result = op_a / op_b;
      end
      4'd6: begin
        alu_queue_op = 2'b10;
        if (op_b == 8'd0) alu_calc_err = 1'b1;
        else              alu_result = op_a % op_b;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: applies one instruction to the queue, returns expected error code.
  function automatic int model_exec(input int op, input int imm);
    int a, b, r;
    if (op >= 8) return 3;
    if (op >= 2 && op <= 6 && mq.size() < 2) return 1;
    if (op == 1 && mq.size() == 0) return 1;
    if (op == 0 && mq.size() == DEPTH) return 2;
    if ((op == 5 || op == 6) && mq[1] == 0) return 3;
    case (op)
      0: mq.push_back(imm);
      1: void'(mq.pop_front());
      7: ;
      default: begin
        a = mq.pop_front();
        b = mq.pop_front();
        case (op)
          2: r = (a + b) % 256;
          3: r = (a * b) % 256;
          4: r = (a - b + 256) % 256;
          5: r = a / b;
          default: r = a % b;
        endcase
        mq.push_back(r);
      end
    endcase
    return 0;
  endfunction

  function automatic int exp_head();
    return (mq.size() > 0) ? mq[0] : 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_done", int'(done), 0);
    check("rst_alu_opcode", int'(alu_opcode), 7);
    check("rst_alu_rst", int'(alu_rst), 1);
    check("rst_ready", int'(instr_ready), 0);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic clear_err();
    int w;
    w = $urandom_range(0, 2);
    repeat (w) @(negedge clk);
    check("err_sticky", int'(err), 1);
    check("err_no_done", int'(done), 0);
    check("alu_rst_idle", int'(alu_rst), 0);
    err_clr = 1'b1;
    #1;
    check("alu_rst_pulse", int'(alu_rst), 1);
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", int'(err), 0);
    check("err_code_cleared", int'(err_code), 0);
    check("alu_rst_off", int'(alu_rst), 0);
    check("count_kept", int'(count), mq.size());
  endtask

  // Starts and ends just after a falling edge with the DUT in IDLE.
  task automatic run_instr(input int op, input int imm);
    int exp_err;
    int k;
    exp_err = model_exec(op, imm);
    check("ready", int'(instr_ready), 1);
    instr_valid = 1'b1;
    instr_op    = 4'(op);
    instr_imm   = 8'(imm);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op    = 4'($urandom);
    instr_imm   = 8'($urandom);
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done || err) break;
    end
    if (exp_err == 0) begin
      check("done_latency", k, 3);
      check("no_err", int'(err), 0);
    end else begin
      check("err_latency", k, 2);
      check("err_code", int'(err_code), exp_err);
      check("err_no_done", int'(done), 0);
    end
    check("count", int'(count), mq.size());
    check("head_data", int'(head_data), exp_head());
    if (exp_err != 0) clear_err();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    run_instr(0, 7); run_instr(0, 3); run_instr(4, 0);
    check("tp_sub_head", int'(head_data), 4);
    check("tp_sub_count", int'(count), 1);

    do_reset();
    run_instr(0, 20); run_instr(0, 6); run_instr(6, 0);
    check("tp_rem_head", int'(head_data), 2);
    run_instr(0, 200); run_instr(3, 0);
    check("tp_mul_head", int'(head_data), 144);

    do_reset();
    run_instr(0, 5); run_instr(0, 0); run_instr(5, 0);
    run_instr(0, 1);
    check("tp_after_clr_count", int'(count), 3);

    do_reset();
    run_instr(1, 0);
    run_instr(0, 9); run_instr(2, 0);
    check("tp_add_underflow_head", int'(head_data), 9);

    do_reset();
    for (int i = 0; i < 9; i++) run_instr(0, 10 + i);
    run_instr(2, 0);
    check("tp_wrap_count", int'(count), 7);
    for (int i = 0; i < 7; i++) run_instr(1, 0);

    // Reset landing on the COMMIT cycle of a PUSH.
    do_reset();
    run_instr(0, 11); run_instr(0, 22);
    instr_valid = 1'b1; instr_op = 4'd0; instr_imm = 8'd33;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_count", int'(count), 0);
    check("rstmid_done", int'(done), 0);
    check("rstmid_ready", int'(instr_ready), 0);
    check("rstmid_alu_rst", int'(alu_rst), 1);
    check("rstmid_alu_opcode", int'(alu_opcode), 7);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);
    check("rstmid_ready_after", int'(instr_ready), 1);
    check("rstmid_head", int'(head_data), 0);
    run_instr(9, 0);

    for (int n = 0; n < 250; n++) begin
      int r, op, imm;
      r = $urandom_range(0, 15);
      if (r <= 5 || r >= 14) op = 0;
      else if (r == 6)       op = 1;
      else if (r <= 11)      op = $urandom_range(2, 6);
      else if (r == 12)      op = 7;
      else                   op = $urandom_range(8, 15);
      imm = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      run_instr(op, imm);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
